hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register-index width.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, total stall cycles for one divide (legal range 2..256).
REQ-003 SHALL have parameter CW, default 32, stall-counter width.
REQ-004 SHALL have ports, with clock and reset first:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- rsD, rtD, rsE, rtE  in  AW  source register indices.
- writeregE, writeregM, writeregW  in  AW  destination indices.
- regwriteE, regwriteM, regwriteW  in  1  write enables.
- memtoregE  in  1  load in E.
- div_startE  in  1  divide instruction in E.
- predict_wrongM  in  1  branch mispredict resolved in M.
- excM  in  1  exception committed in M.
- forwardAE, forwardBE  out  2  forward select: 10 = M, 01 = W, 00 = register file.
- stallF, stallD, stallE  out  1  hold the PC, IF/ID and ID/EX registers.
- flushD, flushE, flushM  out  1  clear the IF/ID, ID/EX and EX/MEM registers.
- div_busy  out  1  divide FSM is not IDLE.
- div_done  out  1  one-cycle pulse that releases the divide.
- stall_cnt  out  CW  count of stallF cycles.

Function
REQ-005 SHALL compute forwardAE combinationally: 10 if rsE!=0, rsE==writeregM and regwriteM; else 01 if rsE!=0, rsE==writeregW and regwriteW; else 00. M has priority over W.
REQ-006 SHALL compute forwardBE with the same rule as REQ-005, using rtE.
REQ-007 SHALL assert lwstall = memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE) & ~stallE.
REQ-008 SHALL implement the divide FSM with states IDLE, BUSY and DONE, plus a down-counter of width clog2(DIV_CYCLES).
REQ-009 In IDLE with div_startE=1 and excM=0: divstall SHALL be asserted in that same cycle; the next state SHALL be BUSY with counter = DIV_CYCLES-2.
REQ-010 In BUSY: divstall SHALL be 1; the counter SHALL decrement each cycle; the FSM SHALL move to DONE on the edge where the counter equals 0.
REQ-011 In DONE: divstall=0 and div_done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-012 The divide instruction SHALL therefore be stalled for exactly DIV_CYCLES cycles and advance in the DONE cycle.
REQ-013 div_startE asserted while in DONE SHALL NOT restart the FSM.
REQ-014 Outputs SHALL be: stallE = divstall; stallD = stallF = (lwstall | divstall) & ~predict_wrongM & ~excM.
REQ-015 flushM SHALL equal divstall | excM, so a bubble enters M while E is held.
REQ-016 flushD SHALL equal predict_wrongM | excM.
REQ-017 flushE SHALL equal lwstall | (predict_wrongM & ~stallE) | excM. A stalled delay-slot instruction in E is preserved on a mispredict.
REQ-018 excM=1 SHALL force stallF, stallD and stallE to 0 in that cycle and the FSM to IDLE on the next edge, from any state.
REQ-019 predict_wrongM and lwstall in the same cycle SHALL give flushD=1, flushE=1, stallF=0 and stallD=0.
REQ-020 stall_cnt SHALL increment by 1 on each edge where stallF=1, saturate at all ones, and never wrap.
REQ-021 div_busy SHALL be 1 when the state is BUSY or DONE.

Reset
REQ-022 When resetn=0 at a rising edge, the module SHALL set: state IDLE, counter 0, stall_cnt 0.
REQ-023 After reset, div_busy=0 and div_done=0; all other outputs SHALL follow REQ-005 to REQ-019 from the inputs with the FSM in IDLE.
REQ-024 Reset SHALL abort an in-progress divide with no pending state retained.

Configuration
REQ-025 Macro HAZARD_DIV_STALL_EN SHALL compile the divide FSM and counter in.
REQ-026 Without HAZARD_DIV_STALL_EN: div_startE is ignored; divstall, stallE, div_busy and div_done are constant 0; all other behaviour is unchanged.

Verification
REQ-027 rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=10; the same with rsE=0 -> forwardAE=00.
REQ-028 memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=1, flushE=1, stall_cnt +1 per cycle; the same with rtE=0 -> no stall.
REQ-029 DIV_CYCLES=4, div_startE pulse -> stallE=1 for 4 cycles, then div_done=1 for 1 cycle, then IDLE; stall_cnt=4.
REQ-030 Divide in BUSY and predict_wrongM=1 -> flushD=1, flushE=0, stallE=1, stallF=0.
REQ-031 excM=1 in the second BUSY cycle -> flushD=flushE=flushM=1, all stalls 0, div_busy=0 next cycle.
REQ-032 resetn=0 for one edge mid-divide -> div_busy=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use stall, multi-cycle divide stall and flush control.
// Optional divide stall FSM is compiled in with `define HAZARD_DIV_STALL_EN.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CW         = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] writeregE,
    input  logic [AW-1:0] writeregM,
    input  logic [AW-1:0] writeregW,
    input  logic          regwriteE,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          memtoregE,
    input  logic          div_startE,
    input  logic          predict_wrongM,
    input  logic          excM,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic          div_busy,
    output logic          div_done,
    output logic [CW-1:0] stall_cnt
);

    logic          lwstall;
    logic          divstall;
    logic [CW-1:0] stall_cnt_reg;

    // Register 0 is hard-wired, so it never forwards; M is newer than W and wins.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input logic [AW-1:0] wr_m, input logic we_m,
                                           input logic [AW-1:0] wr_w, input logic we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0 && src == wr_m && we_m)
            sel = 2'b10;
        else if (src != '0 && src == wr_w && we_w)
            sel = 2'b01;
        return sel;
    endfunction

    assign forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);

    // E-stage destination is not needed: load-use is detected on rtE of the load.
    wire unused_ok = &{1'b0, writeregE, regwriteE};

    assign lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE)) && !stallE;

`ifdef HAZARD_DIV_STALL_EN
    localparam int CNTW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t      state_reg;
    logic [CNTW-1:0] cnt_reg;

    // The IDLE start cycle counts as the first stall cycle, hence the preload of DIV_CYCLES-2.
    always_ff @(posedge clk) begin
        if (!resetn || excM) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_startE) begin
                        state_reg <= BUSY;
                        cnt_reg   <= CNTW'(DIV_CYCLES - 2);
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0)
                        state_reg <= DONE;
                    else
                        cnt_reg <= cnt_reg - 1'b1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign divstall = ((state_reg == IDLE) && div_startE && !excM) || (state_reg == BUSY);
    assign div_busy = (state_reg == BUSY) || (state_reg == DONE);
    assign div_done = (state_reg == DONE);
`else
    wire unused_div = &{1'b0, div_startE, (DIV_CYCLES > 0)};

    assign divstall = 1'b0;
    assign div_busy = 1'b0;
    assign div_done = 1'b0;
`endif

    // An exception overrides every stall so the handler can be fetched immediately.
    assign stallE = divstall && !excM;
    assign stallF = (lwstall || divstall) && !predict_wrongM && !excM;
    assign stallD = stallF;

    assign flushD = predict_wrongM || excM;
    assign flushE = lwstall || (predict_wrongM && !stallE) || excM;
    assign flushM = divstall || excM;

    always_ff @(posedge clk) begin
        if (!resetn)
            stall_cnt_reg <= '0;
        else if (stallF && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected output vectors, a monitor checks them.
// Divide checks are active when HAZARD_DIV_STALL_EN is defined; otherwise the disabled behaviour is checked.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, div_startE, predict_wrongM, excM;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, stallE, flushD, flushE, flushM, div_busy, div_done;
    logic [CW-1:0] stall_cnt;

    // fa fb | sF sD sE fD fE fM busy done | cnt
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(AW), .DIV_CYCLES(4), .CW(CW)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .div_startE(div_startE),
        .predict_wrongM(predict_wrongM), .excM(excM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
    );

    wire [15:0] act_vec = {forwardAE, forwardBE, stallF, stallD, stallE,
                           flushD, flushE, flushM, div_busy, div_done, stall_cnt};

    // Monitor: compares on the falling edge, away from the edge that updates state.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act_vec !== e) begin
                n_fail++;
                $display("FAIL %s: got fa=%b fb=%b sF/sD/sE=%b%b%b fD/fE/fM=%b%b%b busy=%b done=%b cnt=%0d, expected %b",
                         nm, act_vec[15:14], act_vec[13:12], act_vec[11], act_vec[10], act_vec[9],
                         act_vec[8], act_vec[7], act_vec[6], act_vec[5], act_vec[4], act_vec[3:0], e);
            end else begin
                $display("ok   %s: vec=%b", nm, act_vec);
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic sf, input logic sd, input logic se,
                       input logic fd, input logic fe, input logic fm,
                       input logic busy, input logic done, input logic [3:0] cnt);
        exp_q.push_back({fa, fb, sf, sd, se, fd, fe, fm, busy, done, cnt});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; div_startE = 1'b0; predict_wrongM = 1'b0; excM = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        chk("reset_state", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);

        rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
        chk("fwdA_M_over_W", 2'b10, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);
        rsE = 0;
        chk("fwdA_r0", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);
        rsE = 3; rtE = 3; writeregM = 3; regwriteM = 0; writeregW = 3; regwriteW = 1;
        chk("fwd_W_only", 2'b01, 2'b01, 0,0,0, 0,0,0, 0,0, 4'd0);
        rsE = 7; rtE = 7; writeregM = 7; regwriteM = 1; writeregW = 7; regwriteW = 1;
        chk("fwd_both_M", 2'b10, 2'b10, 0,0,0, 0,0,0, 0,0, 4'd0);
        rsE = 4; rtE = 6; writeregM = 5; writeregW = 2;
        chk("fwd_none", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);
        clear_inputs();

        memtoregE = 1; rtE = 8; rsD = 8;
        chk("lwstall_c0", 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0, 4'd0);
        chk("lwstall_c1", 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0, 4'd1);
        chk("lwstall_c2", 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0, 4'd2);
        rtE = 0; rsD = 0;
        chk("lw_rt_zero", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd3);
        rtE = 9; rtD = 9; rsD = 1;
        chk("lwstall_rtD", 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0, 4'd3);
        predict_wrongM = 1;
        chk("lw_plus_mispredict", 2'b00, 2'b00, 0,0,0, 1,1,0, 0,0, 4'd4);
        predict_wrongM = 0; excM = 1;
        chk("lw_plus_exc", 2'b00, 2'b00, 0,0,0, 1,1,1, 0,0, 4'd4);
        clear_inputs();

`ifdef HAZARD_DIV_STALL_EN
        div_startE = 1;
        chk("div_start", 2'b00, 2'b00, 1,1,1, 0,0,1, 0,0, 4'd4);
        div_startE = 0;
        chk("div_busy1", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd5);
        chk("div_busy2", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd6);
        chk("div_busy3", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd7);
        chk("div_done", 2'b00, 2'b00, 0,0,0, 0,0,0, 1,1, 4'd8);
        chk("div_idle", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd8);

        div_startE = 1;
        chk("hold_start", 2'b00, 2'b00, 1,1,1, 0,0,1, 0,0, 4'd8);
        chk("hold_busy1", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd9);
        chk("hold_busy2", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd10);
        chk("hold_busy3", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd11);
        chk("hold_done", 2'b00, 2'b00, 0,0,0, 0,0,0, 1,1, 4'd12);
        div_startE = 0;
        chk("hold_no_restart", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd12);

        div_startE = 1;
        chk("mp_start", 2'b00, 2'b00, 1,1,1, 0,0,1, 0,0, 4'd12);
        div_startE = 0; predict_wrongM = 1;
        chk("mp_in_busy", 2'b00, 2'b00, 0,0,1, 1,0,1, 1,0, 4'd13);
        predict_wrongM = 0;
        chk("mp_busy2", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd13);
        chk("mp_busy3", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd14);
        chk("mp_done", 2'b00, 2'b00, 0,0,0, 0,0,0, 1,1, 4'd15);

        div_startE = 1;
        chk("exc_start_sat", 2'b00, 2'b00, 1,1,1, 0,0,1, 0,0, 4'd15);
        div_startE = 0;
        chk("exc_busy1_sat", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd15);
        excM = 1;
        chk("exc_in_busy2", 2'b00, 2'b00, 0,0,0, 1,1,1, 1,0, 4'd15);
        excM = 0;
        chk("exc_aborted", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd15);

        div_startE = 1;
        chk("rst_start", 2'b00, 2'b00, 1,1,1, 0,0,1, 0,0, 4'd15);
        div_startE = 0;
        chk("rst_busy1", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd15);
        resetn = 0;
        chk("rst_low_busy", 2'b00, 2'b00, 1,1,1, 0,0,1, 1,0, 4'd15);
        resetn = 1;
        chk("rst_cleared", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);
`else
        div_startE = 1;
        chk("div_ignored0", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd4);
        chk("div_ignored1", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd4);
        predict_wrongM = 1;
        chk("div_off_mispredict", 2'b00, 2'b00, 0,0,0, 1,1,0, 0,0, 4'd4);
        clear_inputs();
        memtoregE = 1; rtE = 8; rsD = 8; resetn = 0;
        chk("rst_low_lw", 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0, 4'd4);
        clear_inputs();
        resetn = 1;
        chk("rst_cleared", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd0);
`endif

        // Counter must climb to all ones and stay there.
        memtoregE = 1; rtE = 2; rtD = 2;
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("sat_%0d", i), 2'b00, 2'b00, 1,1,0, 0,1,0, 0,0,
                (i > 15) ? 4'd15 : 4'(i));
        end
        clear_inputs();
        chk("sat_hold", 2'b00, 2'b00, 0,0,0, 0,0,0, 0,0, 4'd15);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
